// File: rtl/clock_ctrl.sv
// Mode/time-set controller for the HH:MM:SS counter: 1 Hz prescaler, RUN/SET FSM,
// field-adjust strobes with auto-repeat, blink enable and inactivity timeout.
module clock_ctrl #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned BLINK_DIV    = 25000000,
  parameter int unsigned TIMEOUT_S    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_tick,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam int unsigned IW = $clog2(TIMEOUT_S + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_DELAY = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_RATE  = HW'(REPEAT_RATE);
  localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_DIV);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    S_RUN = 2'b00,
    S_HR  = 2'b01,
    S_MIN = 2'b10,
    S_SEC = 2'b11
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mode_hist, r_inc_hist;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt, w_hold_inc;
  logic          r_hold_act, w_hold_act_nxt;
  logic          r_hold_rep, w_hold_rep_nxt;
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt, w_blink_inc;
  logic [IW-1:0] r_idle, w_idle_nxt;
  logic          r_sec_tick, r_inc_hr, r_inc_min, r_clr_sec, r_blink;
  logic          w_sec_tick_nxt, w_inc_hr_nxt, w_inc_min_nxt, w_clr_sec_nxt, w_blink_nxt;
  logic          w_mode_rise, w_inc_rise, w_wrap, w_in_set, w_activity;
  logic          w_state_chg, w_repeatable, w_fire_rise, w_fire_rep, w_adjust;

  always_comb begin
    w_mode_rise  = btn_mode & ~r_mode_hist;
    w_inc_rise   = btn_inc & ~r_inc_hist;
    w_wrap       = (r_presc == PRESC_MAX);
    w_in_set     = (r_state != S_RUN);
    w_activity   = w_mode_rise | w_inc_rise | btn_inc;
    w_hold_inc   = r_hold + 1'b1;
    w_blink_inc  = r_blink_cnt + 1'b1;

    w_state_nxt = r_state;
    if (w_mode_rise) begin
      case (r_state)
        S_RUN:   w_state_nxt = S_HR;
        S_HR:    w_state_nxt = S_MIN;
        S_MIN:   w_state_nxt = S_SEC;
        default: w_state_nxt = S_RUN;
      endcase
    end else if (w_in_set && !w_activity && w_wrap && (r_idle == IDLE_MAX)) begin
      w_state_nxt = S_RUN;
    end
    w_state_chg = (w_state_nxt != r_state);

    // A mode rise always changes state, so it suppresses every adjust strobe here.
    w_repeatable = (r_state == S_HR) || (r_state == S_MIN);
    w_fire_rise  = w_in_set && w_inc_rise && !w_mode_rise;
    w_fire_rep   = w_repeatable && r_hold_act && btn_inc && !w_mode_rise &&
                   (w_hold_inc == (r_hold_rep ? HOLD_RATE : HOLD_DELAY));
    w_adjust     = w_fire_rise | w_fire_rep;

    // Hold tracking only arms on a rise that actually produced a strobe.
    w_hold_nxt     = '0;
    w_hold_act_nxt = 1'b0;
    w_hold_rep_nxt = 1'b0;
    if (!w_state_chg && btn_inc) begin
      if (w_fire_rise && w_repeatable) begin
        w_hold_act_nxt = 1'b1;
      end else if (r_hold_act) begin
        w_hold_act_nxt = 1'b1;
        if (w_fire_rep) begin
          w_hold_rep_nxt = 1'b1;
        end else begin
          w_hold_rep_nxt = r_hold_rep;
          w_hold_nxt     = w_hold_inc;
        end
      end
    end

    if (w_wrap || (w_state_chg && (w_state_nxt == S_RUN))) w_presc_nxt = '0;
    else                                                    w_presc_nxt = r_presc + 1'b1;

    if (w_state_chg || !w_in_set || w_activity) w_idle_nxt = '0;
    else if (w_wrap)                             w_idle_nxt = r_idle + 1'b1;
    else                                         w_idle_nxt = r_idle;

    w_blink_nxt     = r_blink;
    w_blink_cnt_nxt = w_blink_inc;
    if (w_state_nxt == S_RUN) begin
      w_blink_nxt     = 1'b0;
      w_blink_cnt_nxt = '0;
    end else if (w_state_chg || w_adjust) begin
      w_blink_nxt     = 1'b1;
      w_blink_cnt_nxt = '0;
    end else if (w_blink_inc == BLINK_MAX) begin
      w_blink_nxt     = ~r_blink;
      w_blink_cnt_nxt = '0;
    end

    w_sec_tick_nxt = w_wrap && (r_state == S_RUN) && (w_state_nxt == S_RUN);
    w_inc_hr_nxt   = w_adjust && (r_state == S_HR);
    w_inc_min_nxt  = w_adjust && (r_state == S_MIN);
    w_clr_sec_nxt  = w_fire_rise && (r_state == S_SEC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_mode_hist <= 1'b1;
      r_inc_hist  <= 1'b1;
      r_presc     <= '0;
      r_hold      <= '0;
      r_hold_act  <= 1'b0;
      r_hold_rep  <= 1'b0;
      r_blink_cnt <= '0;
      r_idle      <= '0;
      r_sec_tick  <= 1'b0;
      r_inc_hr    <= 1'b0;
      r_inc_min   <= 1'b0;
      r_clr_sec   <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_hist <= btn_mode;
      r_inc_hist  <= btn_inc;
      r_presc     <= w_presc_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_act  <= w_hold_act_nxt;
      r_hold_rep  <= w_hold_rep_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_idle      <= w_idle_nxt;
      r_sec_tick  <= w_sec_tick_nxt;
      r_inc_hr    <= w_inc_hr_nxt;
      r_inc_min   <= w_inc_min_nxt;
      r_clr_sec   <= w_clr_sec_nxt;
      r_blink     <= w_blink_nxt;
    end
  end

  assign sec_tick = r_sec_tick;
  assign inc_hr   = r_inc_hr;
  assign inc_min  = r_inc_min;
  assign clr_sec  = r_clr_sec;
  assign mode     = r_state;
  assign blink    = r_blink;

endmodule
